// File: rtl/dcache_mshr_ctrl_pkg.sv
// Shared types for the data-cache miss status holding registers.
//   mshr_state_e : lifecycle of one outstanding miss entry
//   mshr_entry_t : per-entry bookkeeping (state, block address, type, merge count)
//   sat_inc      : saturating increment used for the merged-miss counter
// Entry field widths follow DCACHE_ADDR_W / DCACHE_MERGE_CNT_W; the top-level
// ADDR_W / MERGE_CNT_W parameters default to these and must stay equal to them.
package dcache_mshr_ctrl_pkg;

  localparam int DCACHE_ADDR_W      = 32;
  localparam int DCACHE_BLOCK_BYTES = 128;
  localparam int DCACHE_MERGE_CNT_W = 3;

  typedef enum logic [1:0] {
    MSHR_FREE    = 2'd0,
    MSHR_PENDING = 2'd1,
    MSHR_ISSUED  = 2'd2
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e                   state;
    logic [DCACHE_ADDR_W-1:0]      addr;      // block-aligned
    logic                          is_write;
    logic [DCACHE_MERGE_CNT_W-1:0] merge_cnt;
  } mshr_entry_t;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [DCACHE_MERGE_CNT_W-1:0] sat_inc(
    input logic [DCACHE_MERGE_CNT_W-1:0] v
  );
    if (&v) begin
      return v;
    end else begin
      return v + {{(DCACHE_MERGE_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dcache_mshr_ctrl_rr_picker.sv
// mshr_rr_picker: purely combinational round-robin picker.
//   req      : N-wide request mask
//   ptr      : index with highest priority this cycle
//   grant    : one-hot grant (all zero when nothing requests)
//   grant_id : binary index of the grant
//   found    : at least one request present
module mshr_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          found
);

  // Scan upward from ptr with wrap-around; the first requester seen wins.
  always_comb begin
    int   idx_s;
    logic hit_s;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_s    = 0;
    hit_s    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s        = int'(ptr) + k;
      idx_s        = (idx_s >= N) ? idx_s - N : idx_s;
      hit_s        = ~found & req[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_id     = hit_s ? IW'(idx_s) : grant_id;
      found        = found | hit_s;
    end
  end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// dcache_mshr_ctrl: non-blocking miss handler between dcache lookup and L2 arbiter.
// Tracks NUM_MSHR outstanding misses; every repair carries its entry id so a
// resolution frees only the entry it names.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   miss_valid/addr/is_write       miss from tag lookup
//   miss_ready, miss_id            acceptance and id of accepted miss (combinational)
//   repair_req_valid/addr/write/id registered repair request; repair_req_acq accepts it
//   repair_resolved, _id           L2 fill done for an id
//   fill_valid/id/addr/write/merge_cnt  one-cycle retire pulse (registered)
//   mshr_busy                      any entry not FREE
// Build option: DCACHE_MSHR_MERGE_EN merges a miss into a live entry with the
// same block address and type instead of allocating a new entry.
module dcache_mshr_ctrl
  import dcache_mshr_ctrl_pkg::*;
#(
  parameter  int ADDR_W      = DCACHE_ADDR_W,
  parameter  int NUM_MSHR    = 4,
  parameter  int BLOCK_BYTES = DCACHE_BLOCK_BYTES,
  parameter  int MERGE_CNT_W = DCACHE_MERGE_CNT_W,
  localparam int ID_W        = $clog2(NUM_MSHR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [ADDR_W-1:0]      miss_addr,
  input  logic                   miss_is_write,
  output logic                   miss_ready,
  output logic [ID_W-1:0]        miss_id,
  output logic                   repair_req_valid,
  output logic [ADDR_W-1:0]      repair_req_addr,
  output logic                   repair_req_write,
  output logic [ID_W-1:0]        repair_req_id,
  input  logic                   repair_req_acq,
  input  logic                   repair_resolved,
  input  logic [ID_W-1:0]        repair_resolved_id,
  output logic                   fill_valid,
  output logic [ID_W-1:0]        fill_id,
  output logic [ADDR_W-1:0]      fill_addr,
  output logic                   fill_write,
  output logic [MERGE_CNT_W-1:0] fill_merge_cnt,
  output logic                   mshr_busy
);

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

  mshr_entry_t            entries_r [NUM_MSHR];
  logic [ID_W-1:0]        rr_r;
  logic                   req_valid_r;
  logic [ID_W-1:0]        req_id_r;
  logic [ADDR_W-1:0]      req_addr_r;
  logic                   req_write_r;
  logic                   fill_valid_r;
  logic [ID_W-1:0]        fill_id_r;
  logic [ADDR_W-1:0]      fill_addr_r;
  logic                   fill_write_r;
  logic [MERGE_CNT_W-1:0] fill_cnt_r;

  logic [NUM_MSHR-1:0] free_s, pend_s, pend_nxt_s, pick_oh_s;
  logic [ID_W-1:0]     alloc_id_s, merge_id_s, rr_nxt_s, pick_id_s;
  logic [ADDR_W-1:0]   miss_blk_s, pick_addr_s;
  logic                merge_hit_s, accept_s, alloc_s, acq_s, resolve_ok_s;
  logic                pick_any_s, pick_write_s;

  assign miss_blk_s = miss_addr & BLK_MASK;

  // Per-entry state decode and lowest-index free entry.
  always_comb begin
    free_s     = '0;
    pend_s     = '0;
    alloc_id_s = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      free_s[i] = (entries_r[i].state == MSHR_FREE);
      pend_s[i] = (entries_r[i].state == MSHR_PENDING);
    end
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      alloc_id_s = free_s[i] ? ID_W'(i) : alloc_id_s;
    end
  end

  // Only an ISSUED entry can be resolved; PENDING (incl. the acq cycle) and FREE ids are ignored.
  assign resolve_ok_s = repair_resolved & (entries_r[repair_resolved_id].state == MSHR_ISSUED);

`ifdef DCACHE_MSHR_MERGE_EN
  logic [NUM_MSHR-1:0] merge_vec_s;

  // Same block and type on a live entry; an entry retiring this cycle is not a merge target.
  always_comb begin
    merge_vec_s = '0;
    merge_id_s  = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      merge_vec_s[i] = (entries_r[i].state != MSHR_FREE) &&
                       (entries_r[i].addr == miss_blk_s) &&
                       (entries_r[i].is_write == miss_is_write) &&
                       !(resolve_ok_s && (repair_resolved_id == ID_W'(i)));
    end
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      merge_id_s = merge_vec_s[i] ? ID_W'(i) : merge_id_s;
    end
  end

  assign merge_hit_s = |merge_vec_s;
`else
  assign merge_hit_s = 1'b0;
  assign merge_id_s  = '0;
`endif

  assign miss_ready = (|free_s) | merge_hit_s;
  assign miss_id    = merge_hit_s ? merge_id_s : alloc_id_s;
  assign accept_s   = miss_valid & miss_ready;
  assign alloc_s    = accept_s & ~merge_hit_s;
  assign acq_s      = req_valid_r & repair_req_acq;

  // Pending set and rr pointer as they will be after this cycle, so the next
  // request can be loaded straight into the output register.
  always_comb begin
    pend_nxt_s              = pend_s;
    pend_nxt_s[req_id_r]    = pend_s[req_id_r] & ~acq_s;
    pend_nxt_s[alloc_id_s]  = pend_nxt_s[alloc_id_s] | alloc_s;
    rr_nxt_s = acq_s ? ((req_id_r == ID_W'(NUM_MSHR - 1)) ? '0 : req_id_r + ID_W'(1)) : rr_r;
  end

  mshr_rr_picker #(.N(NUM_MSHR)) u_picker (
    .req      (pend_nxt_s),
    .ptr      (rr_nxt_s),
    .grant    (pick_oh_s),
    .grant_id (pick_id_s),
    .found    (pick_any_s)
  );

  // One-hot mux of the picked entry; a same-cycle allocation is forwarded from the miss port.
  always_comb begin
    logic fwd_s;
    pick_addr_s  = '0;
    pick_write_s = 1'b0;
    fwd_s        = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      fwd_s        = alloc_s && (alloc_id_s == ID_W'(i));
      pick_addr_s  = pick_addr_s | (pick_oh_s[i] ? (fwd_s ? miss_blk_s : entries_r[i].addr) : '0);
      pick_write_s = pick_write_s | (pick_oh_s[i] & (fwd_s ? miss_is_write : entries_r[i].is_write));
    end
  end

  // Entry table, round-robin pointer, request register and retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        entries_r[i] <= '{state: MSHR_FREE, addr: '0, is_write: 1'b0, merge_cnt: '0};
      end
      rr_r         <= '0;
      req_valid_r  <= 1'b0;
      req_id_r     <= '0;
      req_addr_r   <= '0;
      req_write_r  <= 1'b0;
      fill_valid_r <= 1'b0;
      fill_id_r    <= '0;
      fill_addr_r  <= '0;
      fill_write_r <= 1'b0;
      fill_cnt_r   <= '0;
    end else begin
      if (alloc_s) begin
        entries_r[alloc_id_s].state     <= MSHR_PENDING;
        entries_r[alloc_id_s].addr      <= miss_blk_s;
        entries_r[alloc_id_s].is_write  <= miss_is_write;
        entries_r[alloc_id_s].merge_cnt <= '0;
      end
`ifdef DCACHE_MSHR_MERGE_EN
      if (accept_s && merge_hit_s) begin
        entries_r[merge_id_s].merge_cnt <= sat_inc(entries_r[merge_id_s].merge_cnt);
      end
`endif
      if (acq_s) begin
        entries_r[req_id_r].state <= MSHR_ISSUED;
      end
      if (resolve_ok_s) begin
        entries_r[repair_resolved_id].state <= MSHR_FREE;
        fill_id_r    <= repair_resolved_id;
        fill_addr_r  <= entries_r[repair_resolved_id].addr;
        fill_write_r <= entries_r[repair_resolved_id].is_write;
        fill_cnt_r   <= entries_r[repair_resolved_id].merge_cnt;
      end
      fill_valid_r <= resolve_ok_s;
      rr_r         <= rr_nxt_s;
      // Request is held until accepted; then the next pick is loaded immediately.
      if (!req_valid_r || acq_s) begin
        req_valid_r <= pick_any_s;
        req_id_r    <= pick_id_s;
        req_addr_r  <= pick_addr_s;
        req_write_r <= pick_write_s;
      end
    end
  end

  assign repair_req_valid = req_valid_r;
  assign repair_req_addr  = req_addr_r;
  assign repair_req_write = req_write_r;
  assign repair_req_id    = req_id_r;
  assign fill_valid       = fill_valid_r;
  assign fill_id          = fill_id_r;
  assign fill_addr        = fill_addr_r;
  assign fill_write       = fill_write_r;
  assign fill_merge_cnt   = fill_cnt_r;
  assign mshr_busy        = ~&free_s;

endmodule
